// File: rtl/mul8_dot_accumulator.sv
// Accumulates a run of LEN unsigned 16-bit products into one saturating sum,
// delivered over a valid/ready port with a sticky overflow flag.
module mul8_dot_accumulator #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] len,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [15:0]      prod,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [ACC_W-1:0] sum,
  output logic             sum_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] acc, acc_next;
  logic [LEN_W-1:0] rem, rem_next;
  logic             ovf, ovf_next;
  logic [ACC_W:0]   add_full;
  logic             accept;
  logic             xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      rem   <= rem_next;
      ovf   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    rem_next   = rem;
    ovf_next   = ovf;
    prod_ready = 1'b0;
    sum_valid  = 1'b0;
    accept     = 1'b0;
    xfer       = 1'b0;
    add_full   = {1'b0, acc} + (ACC_W + 1)'(prod);

    case (state)
      IDLE: begin
        prod_ready = 1'b1;
        accept     = prod_valid;
        if (accept) begin
          acc_next = ACC_W'(prod);
          ovf_next = 1'b0;
          // len of 0 or 1 both mean a single-product run
          if (len <= LEN_W'(1)) begin
            state_next = DONE;
          end else begin
            rem_next   = len - LEN_W'(1);
            state_next = ACC;
          end
        end
      end
      ACC: begin
        prod_ready = 1'b1;
        accept     = prod_valid;
        if (accept) begin
          if (add_full[ACC_W]) begin
            acc_next = '1;
            ovf_next = 1'b1;
          end else begin
            acc_next = add_full[ACC_W-1:0];
          end
          rem_next = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        sum_valid = 1'b1;
        xfer      = sum_ready;
        if (xfer) begin
          acc_next   = '0;
          ovf_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sum     = acc;
  assign sum_ovf = ovf;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mul8_dot_accumulator.sv
// Directed-vector bench for mul8_dot_accumulator; a narrow ACC_W=17 copy
// shares the stimulus to exercise saturation.
module tb_mul8_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  len;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] prod;
  logic        sum_valid;
  logic        sum_ready;
  logic [23:0] sum;
  logic        sum_ovf;
  logic        busy;

  logic        prod_ready_n;
  logic        sum_valid_n;
  logic [16:0] sum_n;
  logic        sum_ovf_n;
  logic        busy_n;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  mul8_dot_accumulator #(.ACC_W(24), .LEN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .len        (len),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod       (prod),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum        (sum),
    .sum_ovf    (sum_ovf),
    .busy       (busy)
  );

  mul8_dot_accumulator #(.ACC_W(17), .LEN_W(8)) dut_narrow (
    .clk        (clk),
    .rst        (rst),
    .len        (len),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready_n),
    .prod       (prod),
    .sum_valid  (sum_valid_n),
    .sum_ready  (sum_ready),
    .sum        (sum_n),
    .sum_ovf    (sum_ovf_n),
    .busy       (busy_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge; inputs are driven and outputs sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [15:0] p);
    prod_valid = v;
    prod       = p;
    step();
  endtask

  task automatic release_sum();
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    len        = '0;
    prod_valid = 1'b0;
    prod       = '0;
    sum_ready  = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_prod_ready", prod_ready, 1);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_ovf", sum_ovf, 0);

    // len=4 back-to-back
    len = 8'd4;
    beat(1, 16'd1);
    check("r1_busy", busy, 1);
    beat(1, 16'd2);
    beat(1, 16'd3);
    check("r1_valid_early", sum_valid, 0);
    beat(1, 16'd4);
    prod_valid = 1'b0;
    check("r1_valid", sum_valid, 1);
    check("r1_sum", sum, 10);
    check("r1_ovf", sum_ovf, 0);
    check("r1_ready_done", prod_ready, 0);
    release_sum();
    check("r1_idle_valid", sum_valid, 0);
    check("r1_idle_busy", busy, 0);

    // len=3 of 0xFFFF: wide sums exactly, narrow saturates
    len = 8'd3;
    beat(1, 16'hFFFF);
    beat(1, 16'hFFFF);
    beat(1, 16'hFFFF);
    prod_valid = 1'b0;
    check("r2_sum24", sum, 32'h2FFFD);
    check("r2_ovf24", sum_ovf, 0);
    check("r2_valid17", sum_valid_n, 1);
    check("r2_sum17", sum_n, 32'h1FFFF);
    check("r2_ovf17", sum_ovf_n, 1);
    release_sum();
    check("r2_ovf17_clr", sum_ovf_n, 0);

    // len=2 with a stalled sink and upstream holding the next product
    len = 8'd2;
    beat(1, 16'd5);
    beat(1, 16'd6);
    prod_valid = 1'b1;
    prod       = 16'h0099;
    len        = 8'd1;
    for (int i = 0; i < 5; i++) begin
      check("r3_hold_sum", sum, 11);
      check("r3_hold_ready", prod_ready, 0);
      check("r3_hold_valid", sum_valid, 1);
      step();
    end
    release_sum();
    check("r3_after_valid", sum_valid, 0);
    check("r3_after_ready", prod_ready, 1);
    step();
    prod_valid = 1'b0;
    check("r3_next_valid", sum_valid, 1);
    check("r3_next_sum", sum, 32'h99);
    release_sum();

    // len=0 treated as one product
    len = 8'd0;
    beat(1, 16'h1234);
    prod_valid = 1'b0;
    check("r4_valid", sum_valid, 1);
    check("r4_sum", sum, 32'h1234);
    release_sum();

    // len=5 with gaps and a mid-run len change
    len = 8'd5;
    beat(1, 16'd1);
    len = 8'd2;
    beat(0, 16'd100);
    beat(0, 16'd100);
    beat(1, 16'd2);
    beat(1, 16'd3);
    check("r5_valid_3", sum_valid, 0);
    beat(0, 16'd100);
    beat(1, 16'd4);
    check("r5_valid_4", sum_valid, 0);
    beat(1, 16'd5);
    prod_valid = 1'b0;
    check("r5_valid", sum_valid, 1);
    check("r5_sum", sum, 15);
    release_sum();

    // reset mid-run discards the partial sum
    len = 8'd4;
    beat(1, 16'd10);
    beat(1, 16'd20);
    prod_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("r6_busy", busy, 0);
    check("r6_valid", sum_valid, 0);
    check("r6_ready", prod_ready, 1);
    len = 8'd1;
    beat(1, 16'd7);
    prod_valid = 1'b0;
    check("r6_sum", sum, 7);
    check("r6_ovf", sum_ovf, 0);
    release_sum();

    // reset while DONE drops the pending result
    len = 8'd1;
    beat(1, 16'd9);
    prod_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("r7_valid", sum_valid, 0);
    check("r7_sum", sum, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
